pipelined_priority_mux: RTL and testbench

PIPELINED_PRIORITY_MUX -- requirements
Module: pipelined_priority_mux

---
 rtl/pipelined_priority_mux.sv | 149 ++++++++++++++
 tb/tb_pipelined_priority_mux.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_priority_mux.sv
// Pipelined N-way priority multiplexer: each stage resolves one channel group and
// passes the best {hit, idx, data} so far; no-hit beats can repeat the last hit value.
module pipelined_priority_mux #(
    parameter int N      = 16,
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_sel,
    input  logic                 msb_first,
    input  logic                 hold_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_hit,
    output logic [$clog2(N)-1:0] out_idx
);

    localparam int G  = N / STAGES;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic          hit;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } part_t;

    logic              advance;
    logic [W-1:0]      hold_reg;

    logic [STAGES-1:0] stg_valid;
    logic [N-1:0]      stg_sel  [STAGES];
    logic [N*W-1:0]    stg_data [STAGES];
    logic              stg_msb  [STAGES];
    logic              stg_hold [STAGES];
    part_t             stg_part [STAGES];

    logic [STAGES-1:0] cur_valid;
    logic [N-1:0]      cur_sel  [STAGES];
    logic [N*W-1:0]    cur_data [STAGES];
    logic              cur_msb  [STAGES];
    logic              cur_hold [STAGES];
    part_t             cur_part [STAGES];
    part_t             nxt_part [STAGES];

    // Groups are visited in priority direction, so an earlier hit always wins.
    function automatic part_t resolve(
        input logic [N-1:0]   sel,
        input logic [N*W-1:0] data,
        input logic           msb,
        input int             stage,
        input part_t          carried
    );
        part_t r;
        int    grp;
        int    base;
        r    = carried;
        grp  = msb ? (STAGES - 1 - stage) : stage;
        base = grp * G;
        if (!carried.hit) begin
            if (msb) begin
                for (int j = 0; j < G; j++) begin
                    if (sel[base + j]) begin
                        r.hit  = 1'b1;
                        r.idx  = IW'(base + j);
                        r.data = data[(base + j) * W +: W];
                    end
                end
            end else begin
                for (int j = G - 1; j >= 0; j--) begin
                    if (sel[base + j]) begin
                        r.hit  = 1'b1;
                        r.idx  = IW'(base + j);
                        r.data = data[(base + j) * W +: W];
                    end
                end
            end
        end
        return r;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        cur_valid = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                cur_valid[s] = in_valid;
                cur_sel[s]   = in_sel;
                cur_data[s]  = in_data;
                cur_msb[s]   = msb_first;
                cur_hold[s]  = hold_mode;
                cur_part[s]  = '0;
            end else begin
                cur_valid[s] = stg_valid[s-1];
                cur_sel[s]   = stg_sel[s-1];
                cur_data[s]  = stg_data[s-1];
                cur_msb[s]   = stg_msb[s-1];
                cur_hold[s]  = stg_hold[s-1];
                cur_part[s]  = stg_part[s-1];
            end
            nxt_part[s] = resolve(cur_sel[s], cur_data[s], cur_msb[s], s, cur_part[s]);
        end
    end

    // The whole pipeline shifts together; a stall freezes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stg_sel[s]  <= '0;
                stg_data[s] <= '0;
                stg_msb[s]  <= 1'b0;
                stg_hold[s] <= 1'b0;
                stg_part[s] <= '0;
            end
        end else if (advance) begin
            stg_valid <= cur_valid;
            for (int s = 0; s < STAGES; s++) begin
                stg_sel[s]  <= cur_sel[s];
                stg_data[s] <= cur_data[s];
                stg_msb[s]  <= cur_msb[s];
                stg_hold[s] <= cur_hold[s];
                stg_part[s] <= nxt_part[s];
            end
        end
    end

    // Only a delivered hit updates the held value; bubbles and stalls leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (out_valid && out_ready && out_hit) begin
            hold_reg <= stg_part[STAGES-1].data;
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_hit   = stg_part[STAGES-1].hit;
    assign out_idx   = stg_part[STAGES-1].hit ? stg_part[STAGES-1].idx : '0;
    assign out_data  = stg_part[STAGES-1].hit  ? stg_part[STAGES-1].data :
                       stg_hold[STAGES-1]      ? hold_reg : '0;

endmodule

// File: tb/tb_pipelined_priority_mux.sv
// Self-checking bench for pipelined_priority_mux (N=16, W=8, STAGES=2): directed
// scenarios plus randomized traffic scored against a transaction-level model.
module tb_pipelined_priority_mux;

    localparam int N = 16;
    localparam int W = 8;
    localparam int STAGES = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_sel;
    logic           msb_first;
    logic           hold_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_hit;
    logic [3:0]     out_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]   sel;
        logic [N*W-1:0] data;
        logic           msb;
        logic           hold;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_b;
    logic [W-1:0] model_hold;
    logic         e_hit;
    int           e_idx;
    logic [W-1:0] e_data;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_hit;
    logic [3:0]   prev_idx;
    logic [N*W-1:0] ramp;

    pipelined_priority_mux #(.N(N), .W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .msb_first (msb_first),
        .hold_mode (hold_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hit   (out_hit),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] sel, input logic [N*W-1:0] data,
                                 input logic msb, input logic hold);
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        msb_first = msb;
        hold_mode = hold;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] rand_sel();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return N'(1) << $urandom_range(0, N-1);
            2:       return N'($urandom);
            3:       return '1;
            default: return N'($urandom & $urandom);
        endcase
    endfunction

    // Transaction monitor: inputs settle at posedge+1, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_hold = '0;
            prev_stall = 1'b0;
        end else begin
            checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, prev_data);
                checkOutput("stall_hit", out_hit, prev_hit);
                checkOutput("stall_idx", out_idx, prev_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 1, 0);
                end else begin
                    mon_b = exp_q.pop_front();
                    e_hit = 1'b0;
                    e_idx = 0;
                    for (int k = 0; k < N; k++) begin
                        if (mon_b.sel[k] && (!e_hit || mon_b.msb)) begin
                            e_hit = 1'b1;
                            e_idx = k;
                        end
                    end
                    if (e_hit) e_data = mon_b.data[e_idx*W +: W];
                    else       e_data = mon_b.hold ? model_hold : '0;
                    checkOutput("out_hit", out_hit, e_hit);
                    checkOutput("out_idx", out_idx, e_idx);
                    checkOutput("out_data", out_data, e_data);
                    if (e_hit) model_hold = e_data;
                end
            end
            if (in_valid && in_ready) begin
                mon_b.sel  = in_sel;
                mon_b.data = in_data;
                mon_b.msb  = msb_first;
                mon_b.hold = hold_mode;
                exp_q.push_back(mon_b);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_hit   = out_hit;
            prev_idx   = out_idx;
        end
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        msb_first = 1'b0;
        hold_mode = 1'b0;
        for (int k = 0; k < N; k++) ramp[k*W +: W] = 8'hA0 + 8'(k);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_hit", out_hit, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        // lowest then highest winner, latency two cycles
        applyStimulus(1, 16'h0090, ramp, 0, 0);
        checkOutput("lat_lsb_early", out_valid, 0);
        applyStimulus(1, 16'h0090, ramp, 1, 0);
        checkOutput("lat_lsb_valid", out_valid, 1);
        checkOutput("lsb_data", out_data, 8'hA4);
        checkOutput("lsb_idx", out_idx, 4);
        checkOutput("lsb_hit", out_hit, 1);
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("msb_valid", out_valid, 1);
        checkOutput("msb_data", out_data, 8'hA7);
        checkOutput("msb_idx", out_idx, 7);
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("drain_valid", out_valid, 0);

        // eight back-to-back beats
        for (int c = 0; c < 12; c++) begin
            applyStimulus(c < 8, rand_sel(), rand_data(), 1'($urandom), 1'($urandom));
            checkOutput("b2b_valid", out_valid, (c + 1 >= 2 && c + 1 <= 9));
        end

        // hold behaviour after a hit beat
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1, 16'h0008, {ramp[N*W-1:4*W], 8'h33, ramp[3*W-1:0]}, 0, 0);
            applyStimulus(1, 16'h0000, ramp, 0, (r == 0));
            checkOutput("hold_a_data", out_data, 8'h33);
            applyStimulus(0, '0, '0, 0, 0);
            checkOutput("hold_b_valid", out_valid, 1);
            checkOutput("hold_b_data", out_data, (r == 0) ? 8'h33 : 8'h00);
            checkOutput("hold_b_hit", out_hit, 0);
            checkOutput("hold_b_idx", out_idx, 0);
            applyStimulus(0, '0, '0, 0, 0);
        end

        // back-pressure with a full pipeline
        out_ready = 1'b0;
        applyStimulus(1, rand_sel(), rand_data(), 0, 1);
        applyStimulus(1, rand_sel(), rand_data(), 1, 1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("stall_in_ready", in_ready, 0);
            applyStimulus(1, 16'h0100, ramp, 0, 0);
        end
        out_ready = 1'b1;
        applyStimulus(1, 16'h0100, ramp, 0, 0);
        repeat (4) applyStimulus(0, '0, '0, 0, 0);
        checkOutput("stall_drained", exp_q.size(), 0);

        // reset with beats in flight clears the hold register
        applyStimulus(1, 16'h0002, ramp, 0, 0);
        repeat (3) applyStimulus(0, '0, '0, 0, 0);
        applyStimulus(1, 16'h0020, ramp, 0, 0);
        applyStimulus(1, 16'h0040, ramp, 0, 0);
        rst_n = 1'b0;
        applyStimulus(1, 16'h0080, ramp, 0, 0);
        rst_n = 1'b1;
        checkOutput("rst_mid_valid", out_valid, 0);
        applyStimulus(1, 16'h0000, ramp, 0, 1);
        checkOutput("rst_mid_valid2", out_valid, 0);
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("rst_hold_valid", out_valid, 1);
        checkOutput("rst_hold_data", out_data, 8'h00);
        checkOutput("rst_hold_hit", out_hit, 0);

        // full select with alternating direction, then last-group win
        for (int c = 0; c < 8; c++) begin
            applyStimulus(c < 6, 16'hFFFF, rand_data(), 1'(c % 2), 0);
            if (c + 1 >= 2 && c + 1 <= 7)
                checkOutput("alt_idx", out_idx, ((c - 1) % 2 == 1) ? 15 : 0);
        end
        applyStimulus(1, 16'h8000, ramp, 0, 0);
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("last_group_idx", out_idx, 15);
        checkOutput("last_group_data", out_data, 8'hAF);

        // randomized traffic with back-pressure and occasional reset
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 99) != 0);
            applyStimulus(1'($urandom), rand_sel(), rand_data(), 1'($urandom), 1'($urandom));
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) applyStimulus(0, '0, '0, 0, 0);
        checkOutput("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
